rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Parametrised N-channel arbitrating multiplexer with valid/ready handshakes and a registered output stage.
- Successor to the combinational select muxes: replaces the external select with internal arbitration, either round-robin or fixed-priority.
- Shares one downstream port among several requesters, for example I-fetch and D-access sharing a memory bus, or multiple writeback sources.
- Latency is 1 cycle. Throughput is 1 transfer per cycle.

Parameters:
- WIDTH, 32, data width per channel.
- NCH, 4, number of input channels; legal range 2..16.
- SELW, 2, width of channel index; must equal clog2(NCH).
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  NCH  per-channel request; bit i belongs to channel i.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NCH  one-hot or zero; channel i is accepted on the cycle in_valid[i] & in_ready[i].
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data of the held beat.
- out_sel  output  SELW  index of the channel that supplied the held beat.
- out_ready  input  1  downstream accepts the beat on the cycle out_valid & out_ready.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
  - Any held beat is discarded.
  - in_ready is 0 during the cycle rst is high.
- Output register capacity: 1 beat.
  - load_ok = ~out_valid | out_ready, which gives pass-through on drain.
  - Combinational path from out_ready to in_ready is permitted.
- Grant (combinational) is computed only from in_valid and ptr.
  - MODE=0: the first i with in_valid[i]=1, searching ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1 (mod NCH).
  - MODE=1: the lowest i with in_valid[i]=1; ptr is ignored.
  - in_ready[g] = load_ok & any(in_valid) for the granted g. All other bits are 0.
  - Never more than one in_ready bit is set.
- Transfer in, on a clk edge with a granted channel g and load_ok=1:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - MODE=0: ptr <= (g+1) mod NCH.
- Drain only, when out_valid & out_ready and no request: out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous drain and load in the same cycle: the new beat replaces the old one with out_valid kept at 1. This gives full throughput.
- Stall, when out_valid & ~out_ready:
  - out_data, out_sel, out_valid and ptr are held stable.
  - All in_ready bits are 0.
- ptr changes only on an accepted input transfer. A request that is withdrawn without a transfer does not move ptr.
- Upstream obligations:
  - Once in_valid[i] is raised, it stays high with stable data until accepted.
  - The block does not check this; the bench asserts it.
- Fairness:
  - MODE=0: with all channels continuously requesting, grants cycle 0,1,...,NCH-1,0,...
  - MODE=0: a requesting channel waits at most NCH-1 transfers.
  - MODE=1: starvation of high indices is permitted.
- No data bits are transformed. Widths are exact. No X is allowed on out_* after reset.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_sel=0. First grant after release goes to ch0.
- RR rotation (MODE=0, NCH=4), all valid, out_ready=1, ch i data = 32'hA0+i:
  - out_sel sequence is 0,1,2,3,0,1.
  - out_data is 0xA0,0xA1,0xA2,0xA3,... on consecutive cycles with no bubbles.
- Pointer skip: ptr=1, in_valid=4'b1001 -> grant ch3, then ptr=0. Next grant is ch0 if it is still valid.
- Backpressure: out_ready=0 for 3 cycles with a beat held (out_sel=2, data 0x55) -> out_* stable, in_ready=0, ptr unchanged. When out_ready rises, beat 0x55 drains and the next grant loads in the same cycle.
- Fixed priority (MODE=1): in_valid=4'b1110 then 4'b1111 -> grants 1, then 0. ch3 is starved while ch0..2 remain valid.
- Reset mid-stall: out_valid=1, out_ready=0, pulse rst for 1 cycle -> out_valid=0, ptr=0 on the next cycle. The held beat is never presented with out_ready high.

Source files
------------

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating multiplexer: round-robin or fixed-priority grant into a
// single registered output stage with valid/ready handshakes on both sides.
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  grant_idx;
  logic [SELW-1:0]  probe_idx;
  logic             grant_found;
  logic             load_ok;
  logic             take;
  logic [WIDTH-1:0] grant_data;

  // The register can accept a new beat when empty or when its beat leaves this cycle.
  assign load_ok = ~out_valid | out_ready;
  assign take    = load_ok & (|in_valid) & ~rst;

  // Search order starts at ptr in round-robin mode and at 0 in fixed-priority mode.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    probe_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (MODE == 0) begin
        probe_idx = SELW'((int'(ptr) + k) % NCH);
      end else begin
        probe_idx = SELW'(k);
      end
      if (!grant_found && in_valid[probe_idx]) begin
        grant_found = 1'b1;
        grant_idx   = probe_idx;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (take) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  assign grant_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_sel   <= grant_idx;
      if (MODE == 0) begin
        if (int'(grant_idx) == NCH - 1) begin
          ptr <= '0;
        end else begin
          ptr <= grant_idx + 1'b1;
        end
      end
    end else if (out_ready) begin
      // Drain with nothing to load: data and select keep their last values.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: one round-robin and one fixed-priority instance
// driven by shared stimulus, checked against hand-computed vector tables.
module tb_rr_arb_mux;

  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  typedef struct {
    logic             rst;
    logic [NCH-1:0]   iv;
    logic             ordy;
    logic [NCH-1:0]   er;
    logic             ev;
    logic [SELW-1:0]  es;
    logic [WIDTH-1:0] ed;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NCH-1:0]       in_valid = '0;
  logic [NCH*WIDTH-1:0] in_data;
  logic                 out_ready = 1'b1;
  logic [WIDTH-1:0]     ch_data [NCH];

  logic [NCH-1:0]   ready0, ready1;
  logic             ovalid0, ovalid1;
  logic [WIDTH-1:0] odata0, odata1;
  logic [SELW-1:0]  osel0, osel1;

  logic             active = 1'b0;
  int               total = 0;
  int               bad = 0;
  vec_t             tbl [$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = ch_data[i];
  end

  rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ready0), .out_valid(ovalid0), .out_data(odata0),
    .out_sel(osel0), .out_ready(out_ready)
  );

  rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ready1), .out_valid(ovalid1), .out_data(odata1),
    .out_sel(osel1), .out_ready(out_ready)
  );

  // Upstream hold rule: a request not yet accepted keeps valid high and data stable.
  logic [NCH-1:0]       pend;
  logic [NCH*WIDTH-1:0] pdata;
  always @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (pend[i]) begin
          assert (in_valid[i] && in_data[i*WIDTH +: WIDTH] == pdata[i*WIDTH +: WIDTH])
            else $error("FAIL upstream hold ch%0d", i);
        end
      end
      pend  <= in_valid & ~(active ? ready1 : ready0);
      pdata <= in_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] iv, input logic o,
                              input logic [3:0] er, input logic ev,
                              input logic [1:0] es, input logic [31:0] ed);
    vec_t v;
    v.rst = r; v.iv = iv; v.ordy = o; v.er = er; v.ev = ev; v.es = es; v.ed = ed;
    return v;
  endfunction

  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    rst       = v.rst;
    in_valid  = v.iv;
    out_ready = v.ordy;
    #1;
    check({tag, " in_ready"}, 32'(active ? ready1 : ready0), 32'(v.er));
    @(posedge clk);
    #1;
    check({tag, " out_valid"}, 32'(active ? ovalid1 : ovalid0), 32'(v.ev));
    check({tag, " out_sel"},   32'(active ? osel1 : osel0),     32'(v.es));
    check({tag, " out_data"},  active ? odata1 : odata0,         v.ed);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) apply($sformatf("%s[%0d]", tag, i), tbl[i]);
    tbl.delete();
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) ch_data[i] = 32'hA0 + 32'(i);

    // Reset held two cycles with everyone requesting, then round-robin rotation,
    // draining, drain-only, and the pointer skip from ptr=1 over ch1/ch2 to ch3.
    tbl.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 0, 32'h0));
    tbl.push_back(mk(1, 4'b1111, 1, 4'b0000, 0, 0, 32'h0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 0, 32'hA0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 1, 1, 32'hA1));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0100, 1, 2, 32'hA2));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b1000, 1, 3, 32'hA3));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 0, 32'hA0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0010, 1, 1, 32'hA1));
    tbl.push_back(mk(0, 4'b1101, 1, 4'b0100, 1, 2, 32'hA2));
    tbl.push_back(mk(0, 4'b1001, 1, 4'b1000, 1, 3, 32'hA3));
    tbl.push_back(mk(0, 4'b0001, 1, 4'b0001, 1, 0, 32'hA0));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 32'hA0));
    tbl.push_back(mk(0, 4'b1001, 1, 4'b1000, 1, 3, 32'hA3));
    tbl.push_back(mk(0, 4'b0001, 1, 4'b0001, 1, 0, 32'hA0));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 32'hA0));
    run_table("rr");

    // Backpressure: ch2 beat 0x55 held three stalled cycles (ptr sits at 3),
    // then drains while ch3 loads in the same cycle.
    ch_data[2] = 32'h55;
    apply("bp load",   mk(0, 4'b0100, 0, 4'b0100, 1, 2, 32'h55));
    for (int i = 0; i < 3; i++)
      apply($sformatf("bp stall%0d", i), mk(0, 4'b1001, 0, 4'b0000, 1, 2, 32'h55));
    apply("bp release", mk(0, 4'b1001, 1, 4'b1000, 1, 3, 32'hA3));
    apply("bp next",    mk(0, 4'b0001, 1, 4'b0001, 1, 0, 32'hA0));
    apply("bp drain",   mk(0, 4'b0000, 1, 4'b0000, 0, 0, 32'hA0));
    ch_data[2] = 32'hA2;

    // Reset while stalled: beat discarded, ptr back to 0 so ch0 wins next.
    apply("rs load",  mk(0, 4'b0010, 0, 4'b0010, 1, 1, 32'hA1));
    apply("rs stall", mk(0, 4'b0000, 0, 4'b0000, 1, 1, 32'hA1));
    apply("rs pulse", mk(1, 4'b0000, 0, 4'b0000, 0, 0, 32'h0));
    apply("rs after", mk(0, 4'b1111, 1, 4'b0001, 1, 0, 32'hA0));

    // Fixed priority: lowest index wins, ch3 starved while ch0..2 keep requesting.
    active = 1'b1;
    tbl.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 0, 32'h0));
    tbl.push_back(mk(0, 4'b1110, 1, 4'b0010, 1, 1, 32'hA1));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 0, 32'hA0));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 0, 32'hA0));
    tbl.push_back(mk(0, 4'b1110, 1, 4'b0010, 1, 1, 32'hA1));
    tbl.push_back(mk(0, 4'b1111, 1, 4'b0001, 1, 0, 32'hA0));
    run_table("fp");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
